// File: rtl/uart_rx_word.sv
// UART 8N1 receiver that packs 1-4 consecutive bytes (LSB-first, byte 0 lowest) into a 32-bit word.
// Latency: 2-clk input sync, then RX_valid 1 clk after the mid-stop sample of the final byte.
// Backpressure: none; a new word overwrites an unread one and flags overrun until RX_read.
module uart_rx_word #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        serial_in,
    input  logic [1:0]  uart_control,
    input  logic        RX_read,
    output logic [31:0] RXREG,
    output logic        RX_valid,
    output logic        RX_busy,
    output logic        frame_error,
    output logic        overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic           rx_meta;
    logic           rx_s;
    logic [CW-1:0]  clk_cnt;
    logic [2:0]     bit_cnt;
    logic [1:0]     byte_idx;
    logic [1:0]     n_bytes;
    logic [7:0]     shreg;
    logic [31:0]    word_buf;
    logic           word_done;
    logic           wait_high;
    logic [31:0]    keep_mask;

    always_comb begin
        keep_mask = '0;
        for (int k = 0; k < 4; k++) begin
            if (2'(k) <= n_bytes) keep_mask[8*k +: 8] = 8'hFF;
        end
    end

    assign RX_busy = (state != IDLE) || (byte_idx != 2'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            byte_idx    <= '0;
            n_bytes     <= '0;
            shreg       <= '0;
            word_buf    <= '0;
            word_done   <= 1'b0;
            wait_high   <= 1'b0;
            RXREG       <= '0;
            RX_valid    <= 1'b0;
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            rx_meta   <= serial_in;
            rx_s      <= rx_meta;
            word_done <= 1'b0;

            if (RX_read) begin
                RX_valid    <= 1'b0;
                frame_error <= 1'b0;
                overrun     <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // After a framing error the line may sit low (break); re-arm only once it returns high.
                    if (wait_high) begin
                        if (rx_s) wait_high <= 1'b0;
                    end else if (!rx_s) begin
                        state   <= START;
                        bit_cnt <= '0;
                        clk_cnt <= '0;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_M1) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            if (byte_idx == 2'd0) n_bytes <= uart_control;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt == FULL_M1) begin
                        clk_cnt <= '0;
                        state   <= IDLE;
                        if (rx_s) begin
                            word_buf[{byte_idx, 3'b000} +: 8] <= shreg;
                            if (byte_idx == n_bytes) begin
                                byte_idx  <= '0;
                                word_done <= 1'b1;
                            end else begin
                                byte_idx <= byte_idx + 2'd1;
                            end
                        end else begin
                            frame_error <= 1'b1;
                            word_buf    <= '0;
                            byte_idx    <= '0;
                            wait_high   <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase

            // Completion beats a same-cycle RX_read: the new word stays valid and is not an overrun.
            if (word_done) begin
                RXREG    <= word_buf & keep_mask;
                RX_valid <= 1'b1;
                word_buf <= '0;
                if (RX_valid && !RX_read) overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: serial frames bit-banged at CLKS_PER_BIT=16, checked against a word-level model.
module tb_uart_rx_word;

    localparam int CPB = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        serial_in = 1'b1;
    logic [1:0]  uart_control = 2'd0;
    logic        RX_read = 1'b0;
    logic [31:0] RXREG;
    logic        RX_valid;
    logic        RX_busy;
    logic        frame_error;
    logic        overrun;

    int total = 0;
    int bad = 0;

    uart_rx_word #(.CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .serial_in    (serial_in),
        .uart_control (uart_control),
        .RX_read      (RX_read),
        .RXREG        (RXREG),
        .RX_valid     (RX_valid),
        .RX_busy      (RX_busy),
        .frame_error  (frame_error),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        serial_in = b;
        tick(CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        serial_in = 1'b1;
        tick(CPB * n);
    endtask

    task automatic read_pulse();
        RX_read = 1'b1;
        tick(1);
        RX_read = 1'b0;
    endtask

    // Word-level model: the first (ctrl+1) bytes placed little-endian, everything above is zero.
    function automatic logic [31:0] model_word(input logic [1:0] ctrl, input logic [31:0] bytes);
        logic [31:0] w = '0;
        for (int k = 0; k <= int'(ctrl); k++) w = w + ({24'd0, bytes[8*k +: 8]} << (8 * k));
        return w;
    endfunction

    vec_t tbl[5];

    initial begin
        logic [7:0]  d;
        logic [31:0] w;
        logic [1:0]  c;
        logic        pending;
        logic        ov_m;
        int          nbytes;

        tbl[0] = '{2'd0, 32'hDEADBEEF, 32'h0000_00EF};
        tbl[1] = '{2'd1, 32'hDEADBEEF, 32'h0000_BEEF};
        tbl[2] = '{2'd2, 32'hDEADBEEF, 32'h00AD_BEEF};
        tbl[3] = '{2'd3, 32'hDEADBEEF, 32'hDEAD_BEEF};
        tbl[4] = '{2'd3, 32'h00FF_80FF, 32'h00FF_80FF};

        // Reset state
        tick(3);
        check("rst_rxreg", RXREG, 32'h0);
        chk1("rst_valid", RX_valid, 1'b0);
        chk1("rst_busy", RX_busy, 1'b0);
        chk1("rst_ferr", frame_error, 1'b0);
        chk1("rst_ovr", overrun, 1'b0);
        reset = 1'b1;
        idle_bits(2);

        // 1: single byte, exact completion latency (start driven just after edge P0, mid-stop at P155)
        uart_control = 2'd0;
        d = 8'hA5;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        serial_in = 1'b1;
        tick(11);
        chk1("t1_valid_before", RX_valid, 1'b0);
        tick(1);
        chk1("t1_valid_latency", RX_valid, 1'b1);
        tick(4);
        check("t1_rxreg", RXREG, 32'h0000_00A5);
        chk1("t1_busy", RX_busy, 1'b0);
        read_pulse();
        chk1("t1_read_clears", RX_valid, 1'b0);

        // 2: four bytes with idle gaps
        uart_control = 2'd3;
        w = 32'h1234_5678;
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], 1'b1);
            if (k < 3) begin
                chk1("t2_valid_early", RX_valid, 1'b0);
                idle_bits((k == 1) ? 40 : int'($urandom_range(0, 40)));
                chk1("t2_busy_gap", RX_busy, 1'b1);
            end
        end
        check("t2_rxreg", RXREG, 32'h1234_5678);
        chk1("t2_valid", RX_valid, 1'b1);
        chk1("t2_busy_done", RX_busy, 1'b0);
        read_pulse();

        // 3: byte count latched at first byte
        uart_control = 2'd1;
        send_byte(8'hCD, 1'b1);
        uart_control = 2'd3;
        chk1("t3_valid_early", RX_valid, 1'b0);
        send_byte(8'hAB, 1'b1);
        check("t3_rxreg", RXREG, 32'h0000_ABCD);
        chk1("t3_valid", RX_valid, 1'b1);
        read_pulse();

        // 4: short glitch is rejected
        uart_control = 2'd0;
        serial_in = 1'b0;
        tick(5);
        serial_in = 1'b1;
        tick(40);
        chk1("t4_valid_glitch", RX_valid, 1'b0);
        chk1("t4_busy_glitch", RX_busy, 1'b0);
        send_byte(8'h3C, 1'b1);
        check("t4_rxreg", RXREG, 32'h0000_003C);
        read_pulse();

        // 5: framing error on second byte, recovery, sticky flag
        uart_control = 2'd1;
        send_byte(8'h11, 1'b1);
        send_byte(8'h99, 1'b0);
        idle_bits(2);
        chk1("t5_ferr", frame_error, 1'b1);
        chk1("t5_valid", RX_valid, 1'b0);
        chk1("t5_busy", RX_busy, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check("t5_rxreg", RXREG, 32'h0000_2211);
        chk1("t5_ferr_sticky", frame_error, 1'b1);
        read_pulse();
        chk1("t5_ferr_clear", frame_error, 1'b0);

        // 6: overrun, then async reset mid-byte
        uart_control = 2'd0;
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        chk1("t6_ovr", overrun, 1'b1);
        check("t6_rxreg", RXREG, 32'h0000_0002);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        reset = 1'b0;
        #1;
        check("t6_rst_rxreg", RXREG, 32'h0);
        chk1("t6_rst_valid", RX_valid, 1'b0);
        chk1("t6_rst_busy", RX_busy, 1'b0);
        chk1("t6_rst_ovr", overrun, 1'b0);
        serial_in = 1'b1;
        tick(3);
        reset = 1'b1;
        idle_bits(2);
        send_byte(8'h55, 1'b1);
        check("t6_rxreg_after_rst", RXREG, 32'h0000_0055);
        chk1("t6_ovr_after_rst", overrun, 1'b0);
        read_pulse();

        // Table vectors
        for (int i = 0; i < 5; i++) begin
            uart_control = tbl[i].ctrl;
            for (int k = 0; k <= int'(tbl[i].ctrl); k++) send_byte(tbl[i].data[8*k +: 8], 1'b1);
            check("tbl_rxreg", RXREG, tbl[i].exp);
            chk1("tbl_valid", RX_valid, 1'b1);
            read_pulse();
        end

        // Random words with mid-word control changes and occasional skipped reads
        pending = 1'b0;
        ov_m = 1'b0;
        for (int n = 0; n < 25; n++) begin
            c = 2'($urandom_range(0, 3));
            w = $urandom;
            uart_control = c;
            nbytes = int'(c) + 1;
            for (int k = 0; k < nbytes; k++) begin
                send_byte(w[8*k +: 8], 1'b1);
                if (k == 0) uart_control = 2'($urandom_range(0, 3));
                if (k < nbytes - 1) idle_bits(int'($urandom_range(0, 3)));
            end
            if (pending) ov_m = 1'b1;
            pending = 1'b1;
            check("rnd_rxreg", RXREG, model_word(c, w));
            chk1("rnd_valid", RX_valid, 1'b1);
            chk1("rnd_ovr", overrun, ov_m);
            if ($urandom_range(0, 2) != 0) begin
                read_pulse();
                pending = 1'b0;
                ov_m = 1'b0;
                chk1("rnd_read_valid", RX_valid, 1'b0);
            end
            idle_bits(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
